// File: rtl/reg_bank_loader.sv
// -----------------------------------------------------------------------------
// reg_bank_loader
//
// Write side of a 16 x 16-bit register bank. The register contents drive
// outR0..outR15 continuously and feed the bus read multiplexer.
//
// A load is accepted with a valid/ready handshake, one register per cycle.
// A 16-cycle clear sequence zeroes one register per cycle for bank
// initialisation.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   inBus          write data
//   dstSel         destination register index (full 4-bit decode)
//   ldValid        load request; source holds inBus/dstSel until accepted
//   ldReady        block can accept a load this cycle (IDLE and out of reset)
//   clrReq         start clear sequence (only looked at in IDLE)
//   clrBusy        clear sequence in progress
//   wrDone         one-cycle pulse: a load was committed at the previous edge
//   wrIdx          index of the committed load (valid with wrDone)
//   outR0..outR15  current register contents
// -----------------------------------------------------------------------------
module reg_bank_loader #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] inBus,
    input  logic [3:0]       dstSel,
    input  logic             ldValid,
    output logic             ldReady,
    input  logic             clrReq,
    output logic             clrBusy,
    output logic             wrDone,
    output logic [3:0]       wrIdx,
    output logic [WIDTH-1:0] outR0,
    output logic [WIDTH-1:0] outR1,
    output logic [WIDTH-1:0] outR2,
    output logic [WIDTH-1:0] outR3,
    output logic [WIDTH-1:0] outR4,
    output logic [WIDTH-1:0] outR5,
    output logic [WIDTH-1:0] outR6,
    output logic [WIDTH-1:0] outR7,
    output logic [WIDTH-1:0] outR8,
    output logic [WIDTH-1:0] outR9,
    output logic [WIDTH-1:0] outR10,
    output logic [WIDTH-1:0] outR11,
    output logic [WIDTH-1:0] outR12,
    output logic [WIDTH-1:0] outR13,
    output logic [WIDTH-1:0] outR14,
    output logic [WIDTH-1:0] outR15
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]       r_state;
    logic [3:0]       r_clr_cnt;
    logic             r_wr_done;
    logic [3:0]       r_wr_idx;
    logic             w_accept;
    logic             w_clearing;
    logic [WIDTH-1:0] w_regs [NREGS];

    // ldReady drops combinationally with rst_n so nothing is offered while
    // the bank is held in reset.
    assign ldReady    = (r_state == ST_IDLE) && rst_n;
    assign w_clearing = (r_state == ST_CLEAR);
    assign clrBusy    = w_clearing;
    assign w_accept   = ldValid && ldReady;

    // Sequencer: IDLE -> CLEAR on clrReq, CLEAR walks clrCnt 0..15 and
    // returns to IDLE on the edge that clears index 15. The 4-bit counter
    // wraps to 0 on that same edge, so it is ready for the next sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clrReq) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= 4'd0;
                    end
                end
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 4'd1;
                    if (r_clr_cnt == 4'd15) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Commit report: pulses for every accepted load, so back-to-back loads
    // keep wrDone high on consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_done <= 1'b0;
            r_wr_idx  <= 4'd0;
        end else if (w_accept) begin
            r_wr_done <= 1'b1;
            r_wr_idx  <= dstSel;
        end else begin
            r_wr_done <= 1'b0;
        end
    end

    assign wrDone = r_wr_done;
    assign wrIdx  = r_wr_idx;

    // One register per slot. A load and a clear never hit the same edge
    // (loads are only accepted in IDLE, clears only happen in CLEAR), so the
    // priority between them is immaterial.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [WIDTH-1:0] r_val;
            logic             w_clr_hit;
            logic             w_ld_hit;

            assign w_clr_hit = w_clearing && (r_clr_cnt == 4'(gi));
            assign w_ld_hit  = w_accept && (dstSel == 4'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_val <= '0;
                end else if (w_clr_hit) begin
                    r_val <= '0;
                end else if (w_ld_hit) begin
                    r_val <= inBus;
                end
            end

            assign w_regs[gi] = r_val;
        end
    endgenerate

    assign outR0  = w_regs[0];
    assign outR1  = w_regs[1];
    assign outR2  = w_regs[2];
    assign outR3  = w_regs[3];
    assign outR4  = w_regs[4];
    assign outR5  = w_regs[5];
    assign outR6  = w_regs[6];
    assign outR7  = w_regs[7];
    assign outR8  = w_regs[8];
    assign outR9  = w_regs[9];
    assign outR10 = w_regs[10];
    assign outR11 = w_regs[11];
    assign outR12 = w_regs[12];
    assign outR13 = w_regs[13];
    assign outR14 = w_regs[14];
    assign outR15 = w_regs[15];

endmodule
